// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding and frame defaults used by the
// receiver, the baud generator and the TX serializer.
package uart_pkg;

    localparam int NB_DATA_DEF      = 8;
    localparam int N_TICKS_DEF      = 16;
    localparam int N_STOP_TICKS_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    // Counter width able to hold the larger of two terminal counts.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous inputs; both flops reset to 1 so an
// idle-high line reads as idle straight out of reset.
module uart_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            meta <= 1'b1;
            o_q  <= 1'b1;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples the synchronized line on i_tick, samples each
// bit at its centre and emits one-cycle done / frame-error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA      = NB_DATA_DEF,
    parameter int N_TICKS      = N_TICKS_DEF,
    parameter int N_STOP_TICKS = N_STOP_TICKS_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err
);

    localparam int TW = cnt_width(N_TICKS, N_STOP_TICKS);
    localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [TW-1:0] MID_LAST  = TW'(N_TICKS / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(N_TICKS - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(N_STOP_TICKS - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(NB_DATA - 1);

    logic               rx_s;
    state_t             state;
    state_t             state_next;
    logic [TW-1:0]      tick_cnt;
    logic [BW-1:0]      bit_cnt;
    logic [NB_DATA-1:0] shift_reg;
    logic               stop_end;
    logic               done_d;
    logic               err_d;

    uart_sync2 u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (rx_s)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!rx_s) state_next = START;
            START: if (i_tick && tick_cnt == MID_LAST) state_next = rx_s ? IDLE : DATA;
            DATA:  if (i_tick && tick_cnt == BIT_LAST && bit_cnt == DATA_LAST) state_next = STOP;
            STOP:  if (i_tick && tick_cnt == STOP_LAST) state_next = IDLE;
        endcase
    end

    // Strobes are decided here and registered below, so they land on the
    // same edge that takes the FSM back to IDLE.
    always_comb begin
        stop_end = (state == STOP) && i_tick && (tick_cnt == STOP_LAST);
        done_d   = stop_end && rx_s;
        err_d    = stop_end && !rx_s;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_done   <= done_d;
            o_frame_err <= err_d;
            if (done_d) o_data <= shift_reg;

            case (state)
                IDLE: begin
                    if (!rx_s) tick_cnt <= '0;
                end
                START: begin
                    if (i_tick) begin
                        if (tick_cnt == MID_LAST) begin
                            if (!rx_s) begin
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            shift_reg <= {rx_s, shift_reg[NB_DATA-1:1]};
                            tick_cnt  <= '0;
                            if (bit_cnt != DATA_LAST) bit_cnt <= bit_cnt + BW'(1);
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                STOP: begin
                    if (i_tick) begin
                        if (tick_cnt == STOP_LAST) begin
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule
